// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory port between instruction fetch and
// data access; data has priority, but fetch is forced through after STARVE_MAX data grants.
module mem_arbiter #(
   parameter int LATENCY    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_valid,
   output logic [31:0] if_rdata,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic        dm_gnt,
   output logic        dm_valid,
   output logic [31:0] dm_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        stall_f
);
   typedef enum logic [1:0] {IDLE, GRANT, WAIT, DONE} state_t;
   localparam logic [3:0] LAT_INIT   = 4'(LATENCY - 1);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   state_t     state;
   logic [3:0] starve_cnt, lat_cnt;
   logic       is_fetch, armed, arb, pick_if;
   // armed holds off arbitration for the first edge after reset release
   assign arb     = armed && (state == IDLE || state == DONE) && (if_req || dm_req);
   assign pick_if = if_req && (!dm_req || starve_cnt == STARVE_LIM);
   assign stall_f = if_req && !if_valid;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         starve_cnt <= '0;
         lat_cnt    <= '0;
         is_fetch   <= 1'b0;
         armed      <= 1'b0;
         if_gnt     <= 1'b0;
         dm_gnt     <= 1'b0;
         if_valid   <= 1'b0;
         dm_valid   <= 1'b0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         armed    <= 1'b1;
         if_gnt   <= 1'b0;
         dm_gnt   <= 1'b0;
         if_valid <= 1'b0;
         dm_valid <= 1'b0;
         mem_en   <= 1'b0;
         case (state)
            GRANT: begin
               state   <= WAIT;
               lat_cnt <= LAT_INIT;
            end
            WAIT: begin
               if (lat_cnt == 4'd0) begin
                  state <= DONE;
                  if (is_fetch) begin
                     if_valid <= 1'b1;
                     if_rdata <= mem_rdata;
                  end else begin
                     dm_valid <= 1'b1;
                     dm_rdata <= mem_we ? '0 : mem_rdata;
                  end
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
         // a losing fetch always has starve_cnt below the limit, so +1 never overshoots
         if (arb) begin
            state      <= GRANT;
            mem_en     <= 1'b1;
            is_fetch   <= pick_if;
            if_gnt     <= pick_if;
            dm_gnt     <= !pick_if;
            mem_addr   <= pick_if ? if_addr : dm_addr;
            mem_we     <= !pick_if && dm_we;
            mem_wdata  <= pick_if ? '0 : dm_wdata;
            starve_cnt <= (pick_if || !if_req) ? '0 : starve_cnt + 4'd1;
         end
      end
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 2, cycles from mem_en pulse to mem_rdata valid (legal 1..15).
REQ-002 Parameter STARVE_MAX, default 4, consecutive data grants tolerated while fetch waits (legal 1..15).
REQ-003 clk  in  1  the one clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 if_req  in  1  fetch request, level, held until if_gnt.
REQ-006 if_addr  in  32  fetch address (PC), stable while if_req high and until if_gnt.
REQ-007 if_gnt  out  1  one-cycle pulse, fetch request accepted.
REQ-008 if_valid  out  1  one-cycle pulse, if_rdata holds the instruction.
REQ-009 if_rdata  out  32  fetched instruction.
REQ-010 dm_req  in  1  data request, level, held until dm_gnt.
REQ-011 dm_we  in  1  data request is a store.
REQ-012 dm_addr, dm_wdata  in  32 each  data address / store data, stable until dm_gnt.
REQ-013 dm_gnt  out  1  one-cycle pulse, data request accepted.
REQ-014 dm_valid  out  1  one-cycle pulse, load data ready or store complete.
REQ-015 dm_rdata  out  32  load data; 0 on store completion.
REQ-016 mem_en, mem_we  out  1 each  memory access strobe / write enable.
REQ-017 mem_addr, mem_wdata  out  32 each  memory address / write data.
REQ-018 mem_rdata  in  32  memory read data.
REQ-019 stall_f  out  1  fetch stall, drives the fetch-stage enable (inverted) via hazard unit.

Function
REQ-020 FSM states IDLE, GRANT, WAIT, DONE; one transaction in flight max.
REQ-021 IDLE: if any request, register winner, go GRANT next edge; else stay IDLE.
REQ-022 Arbitration: data wins over fetch unless starve_cnt == STARVE_MAX with if_req high, then fetch wins.
REQ-023 starve_cnt (4 bits): +1 on data grant while if_req high; cleared on fetch grant or data grant with if_req low; saturates at STARVE_MAX.
REQ-024 GRANT (1 cycle, cycle G): winner's gnt=1, mem_en=1, mem_addr/mem_we/mem_wdata from winner's inputs; mem_we=0 for fetch.
REQ-025 WAIT: latency counter loaded LATENCY-1 at GRANT, decrements; mem_rdata sampled into capture register at cycle G+LATENCY; then DONE.
REQ-026 DONE (cycle G+LATENCY+1): winner's valid=1 with captured data (dm_rdata=0 if store); FSM may arbitrate in this cycle, next GRANT at G+LATENCY+2 earliest.
REQ-027 mem_en, gnt, valid low in all states other than those above; mem_addr/mem_wdata/mem_we held from GRANT until next GRANT.
REQ-028 if_rdata/dm_rdata hold last value between valid pulses.
REQ-029 stall_f = if_req AND NOT if_valid (combinational).
REQ-030 Simultaneous requests in IDLE: REQ-022 decides; loser stays pending, served next arbitration.
REQ-031 Request dropped before gnt: permitted only with no grant pending; arbiter samples requests only in IDLE/DONE.

Reset
REQ-032 rst_n low: FSM IDLE, starve_cnt=0, latency counter 0, all gnt/valid/mem_en/mem_we/stall-related registers 0, rdata registers 0, mem_addr/mem_wdata 0.
REQ-033 Reset mid-transaction aborts it: no valid pulse issued for it after release; first grant no earlier than 2nd edge after rst_n rises.

Verification (LATENCY=2, STARVE_MAX=4)
REQ-034 Fetch only: if_req=1, if_addr=0x40, mem_rdata=0x8C010004 at G+2 -> if_gnt at G, mem_addr=0x40, if_valid at G+3, if_rdata=0x8C010004.
REQ-035 Simultaneous: if_req=dm_req=1 in IDLE, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF -> dm_gnt first with mem_we=1, dm_valid dm_rdata=0; if_gnt at next arbitration.
REQ-036 Starvation: dm_req and if_req held high continuously -> exactly 4 dm_gnt then 1 if_gnt, pattern repeats; starve_cnt never exceeds 4.
REQ-037 Reset abort: rst_n low at cycle G+1 of a fetch -> no if_valid, all outputs 0, stall_f=if_req.
REQ-038 Back-to-back fetches: if_req held, addresses 0x0,0x4,0x8 -> if_gnt spacing exactly 4 cycles, stall_f low only in if_valid cycles.
